// File: rtl/anti_theft_timer.sv
// Countdown timer and free-running 1 Hz strobe for the anti-theft FSM.
// Define ANTI_THEFT_FAST_SIM_EN to shrink the prescaler period to FAST_DIV for simulation.
module anti_theft_timer #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int FAST_DIV = 10,
    parameter int VALUE_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_timer,
    input  logic [VALUE_W-1:0] timer_value,
    output logic               one_hz_enable,
    output logic               timer_expired,
    output logic               busy,
    output logic [VALUE_W-1:0] seconds_left
);

`ifdef ANTI_THEFT_FAST_SIM_EN
    localparam bit FAST_SIM = 1'b1;
`else
    localparam bit FAST_SIM = 1'b0;
`endif

    localparam int DIV   = FAST_SIM ? FAST_DIV : CLK_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_blinkCnt;
    logic [CNT_W-1:0]   r_tickCnt;
    logic [VALUE_W-1:0] r_remaining;
    logic               r_expired;

    // The blink prescaler free-runs; the tick prescaler restarts on every load
    // so each counted second is a full DIV cycles long.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_blinkCnt  <= '0;
            r_tickCnt   <= '0;
            r_remaining <= '0;
            r_expired   <= 1'b0;
        end else begin
            r_expired <= 1'b0;

            if (r_blinkCnt == LAST)
                r_blinkCnt <= '0;
            else
                r_blinkCnt <= r_blinkCnt + CNT_W'(1);

            if (start_timer) begin
                r_tickCnt <= '0;
                if (timer_value != '0) begin
                    r_remaining <= timer_value;
                    r_state     <= COUNT;
                end else begin
                    r_remaining <= '0;
                    r_state     <= IDLE;
                    r_expired   <= 1'b1;
                end
            end else if (r_state == COUNT) begin
                if (r_tickCnt == LAST) begin
                    r_tickCnt <= '0;
                    if (r_remaining > VALUE_W'(1)) begin
                        r_remaining <= r_remaining - VALUE_W'(1);
                    end else begin
                        r_remaining <= '0;
                        r_state     <= IDLE;
                        r_expired   <= 1'b1;
                    end
                end else begin
                    r_tickCnt <= r_tickCnt + CNT_W'(1);
                end
            end else begin
                r_tickCnt <= '0;
            end
        end
    end

    assign one_hz_enable = (r_blinkCnt == LAST);
    assign timer_expired = r_expired;
    assign busy          = (r_state == COUNT);
    assign seconds_left  = r_remaining;

endmodule

// File: tb/tb_anti_theft_timer.sv
// Self-checking bench for anti_theft_timer: directed scenarios then random loads/resets,
// compared every cycle against a deadline-based reference model.
module tb_anti_theft_timer;

    localparam int DIV     = 10;
    localparam int VALUE_W = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start_timer = 1'b0;
    logic [VALUE_W-1:0] timer_value = '0;
    logic               one_hz_enable;
    logic               timer_expired;
    logic               busy;
    logic [VALUE_W-1:0] seconds_left;

    int checks = 0;
    int errors = 0;

    // Reference model state: edge index, last reset edge, and the active load.
    int edgeIdx    = 0;
    int resetEdge  = 0;
    bit active     = 1'b0;
    int loadEdge   = 0;
    int loadN      = 0;
    bit expPulse   = 1'b0;

    anti_theft_timer #(
        .CLK_HZ   (DIV),
        .FAST_DIV (DIV),
        .VALUE_W  (VALUE_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_timer   (start_timer),
        .timer_value   (timer_value),
        .one_hz_enable (one_hz_enable),
        .timer_expired (timer_expired),
        .busy          (busy),
        .seconds_left  (seconds_left)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s at edge %0d: observed=%0d expected=%0d", tag, edgeIdx, obs, exp);
        end
    endtask

    // Drive one edge worth of inputs, advance the model, then check all outputs.
    task automatic applyStimulus(input bit s, input int v, input bit r);
        int expSecs;
        int expBlink;
        start_timer = s;
        timer_value = VALUE_W'(v);
        rst         = r;
        @(posedge clk);
        edgeIdx++;
        expPulse = 1'b0;
        if (r) begin
            resetEdge = edgeIdx;
            active    = 1'b0;
        end else if (s) begin
            loadEdge = edgeIdx;
            if (v != 0) begin
                active = 1'b1;
                loadN  = v;
            end else begin
                active   = 1'b0;
                expPulse = 1'b1;
            end
        end else if (active && edgeIdx == loadEdge + loadN * DIV) begin
            active   = 1'b0;
            expPulse = 1'b1;
        end
        expSecs  = active ? loadN - (edgeIdx - loadEdge) / DIV : 0;
        expBlink = (((edgeIdx - resetEdge) % DIV) == DIV - 1) ? 1 : 0;
        #1;
        checkOutput("one_hz_enable", int'(one_hz_enable), expBlink);
        checkOutput("timer_expired", int'(timer_expired), int'(expPulse));
        checkOutput("busy",          int'(busy),          int'(active));
        checkOutput("seconds_left",  int'(seconds_left),  expSecs);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0);
    endtask

    initial begin
        int rnd;
        $display("[TB] reset");
        applyStimulus(1'b0, 0, 1'b1);
        applyStimulus(1'b0, 0, 1'b1);

        $display("[TB] free-running strobe");
        idle(32);

        $display("[TB] load 3");
        applyStimulus(1'b1, 3, 1'b0);
        idle(35);

        $display("[TB] load 0");
        applyStimulus(1'b1, 0, 1'b0);
        idle(4);

        $display("[TB] load 5 then reload 2");
        applyStimulus(1'b1, 5, 1'b0);
        idle(22);
        applyStimulus(1'b1, 2, 1'b0);
        idle(32);

        $display("[TB] load 1 then reload 4 at expiry edge");
        applyStimulus(1'b1, 1, 1'b0);
        idle(9);
        applyStimulus(1'b1, 4, 1'b0);
        idle(45);

        $display("[TB] load 6 then reset mid-count");
        applyStimulus(1'b1, 6, 1'b0);
        idle(24);
        applyStimulus(1'b0, 0, 1'b1);
        idle(70);

        $display("[TB] random phase");
        for (int i = 0; i < 1500; i++) begin
            rnd = int'($urandom_range(0, 199));
            if (rnd < 2)
                applyStimulus(1'b0, 0, 1'b1);
            else if (rnd < 7)
                applyStimulus(1'b1, int'($urandom_range(0, 15)), 1'b0);
            else
                applyStimulus(1'b0, int'($urandom_range(0, 15)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/anti_theft_timer.md
Name: anti_theft_timer

Overview:
- Countdown timer and 1 Hz tick generator beside the anti-theft FSM.
- Consumes the FSM's start_timer / timer_value load request and counts whole seconds of clk.
- Returns a single-cycle timer_expired pulse to the FSM.
- Also supplies the free-running one_hz_enable strobe that the FSM uses for LED blink.

Parameters:
- CLK_HZ, 100_000_000, clk frequency; prescaler terminal count DIV = CLK_HZ.
- FAST_DIV, 10, prescaler terminal count DIV used when ANTI_THEFT_FAST_SIM_EN is defined.
- VALUE_W, 4, width of timer_value and seconds_left.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- start_timer  in  1  load request, sampled on each rising clk edge.
- timer_value  in  VALUE_W  seconds to count, captured when start_timer=1.
- one_hz_enable  out  1  free-running strobe, high 1 cycle every DIV cycles.
- timer_expired  out  1  registered 1-cycle pulse at end of countdown.
- busy  out  1  high while a countdown is in progress.
- seconds_left  out  VALUE_W  remaining whole seconds; 0 when idle.

Behaviour:
- Reset (synchronous, rst=1 at an edge): both prescalers = 0, state IDLE, remaining = 0.
- Reset values: one_hz_enable=0, timer_expired=0, busy=0, seconds_left=0.
- Reset mid-count abandons the countdown; no expiry pulse is produced.
- Blink prescaler: counter 0..DIV-1, wraps to 0, never cleared by start_timer.
  - one_hz_enable = (blink_cnt == DIV-1), decoded from the register.
  - First high in the DIV-th cycle after rst deasserts, then every DIV cycles.
- Second prescaler (tick_cnt): separate counter, cleared on every load, so each counted second is exactly DIV cycles.
- State machine, 2 states:
  - IDLE: busy=0, remaining=0.
  - COUNT: busy=1, seconds_left = remaining.
- Load (any state, start_timer=1 at edge k):
  - tick_cnt <= 0.
  - timer_value != 0: remaining <= timer_value, state <= COUNT.
  - timer_value == 0: state <= IDLE, timer_expired high during cycle k+1.
- COUNT, no load, tick_cnt == DIV-1: tick_cnt <= 0.
  - remaining > 1: remaining <= remaining-1.
  - remaining == 1: remaining <= 0, state <= IDLE, timer_expired <= 1 for exactly one cycle.
- COUNT, otherwise: tick_cnt <= tick_cnt+1.
- Latency: load at edge k with N>0 → timer_expired high for the single cycle after edge k+N*DIV. seconds_left steps N, N-1 … 1, then 0 with the pulse.
- Simultaneous events:
  - start_timer at the expiry edge: load wins; no pulse; new count starts.
  - start_timer while COUNT: restart with the new value; the old count is discarded.
- IDLE with no load: tick_cnt held at 0; timer_expired stays 0.
- Arithmetic: remaining is unsigned VALUE_W and never decrements below 0. tick_cnt width is $clog2(DIV), minimum 1.

Optional Feature:
- Macro ANTI_THEFT_FAST_SIM_EN.
- Defined: DIV = FAST_DIV for both prescalers, giving short simulation runs.
- Not defined: DIV = CLK_HZ (real seconds).
- All other behaviour is identical in both builds.

Test Plan (ANTI_THEFT_FAST_SIM_EN defined, FAST_DIV=10):
1. Release rst, no starts → one_hz_enable high in cycles 9, 19, 29 after release, 1 cycle wide; timer_expired, busy and seconds_left stay 0.
2. start_timer=1, timer_value=3 at edge k → busy=1 from k+1; seconds_left 3/2/1 changing at k+10/k+20; timer_expired high only in the cycle after edge k+30; then busy=0, seconds_left=0.
3. start_timer=1, timer_value=0 → timer_expired high exactly the next cycle; busy never asserts.
4. Load 5 at edge k, reload 2 at edge k+23 → no pulse near k+50; timer_expired only in the cycle after edge k+43.
5. Load 1 at edge k, start_timer=1 with value 4 at edge k+10 → no pulse after k+10; pulse after edge k+50.
6. Load 6, assert rst at edge k+25 → all outputs 0 next cycle; no timer_expired ever; one_hz_enable restarts its phase from reset.
